// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Writer side of the instruction memory. Accepts a program as a
//               byte stream over a valid/ready handshake, assembles big-endian
//               32-bit words and writes them to consecutive word addresses
//               starting at BASE_ADDY. Holds the CPU until the load finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
  parameter logic [15:0] BASE_ADDY  = 16'h0000,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter logic [31:0] END_MARKER = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] mem_addy,
  output logic [31:0] mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic [16:0] word_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // 17 bits so that the full 65536-word limit is representable.
  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  logic [1:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_reg;
  logic [15:0] word_addy;

  logic        handshake;
  logic [16:0] next_count;

  // byte_ready is registered and only high in LOAD, so the handshake is
  // implicitly restricted to LOAD cycles.
  assign handshake  = byte_valid & byte_ready;
  assign next_count = word_count + 17'd1;

  // Load sequencer: byte assembly, word write-out and CPU hold/release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'd0;
      word_addy  <= 16'd0;
      byte_ready <= 1'b0;
      mem_addy   <= 16'd0;
      mem_data   <= 32'd0;
      mem_write  <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      word_count <= 17'd0;
    end else begin
      // Write strobe is a single-cycle pulse unless WRITE re-asserts it.
      mem_write <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            byte_ready <= 1'b1;
            byte_cnt   <= 2'd0;
            word_addy  <= BASE_ADDY;
            word_count <= 17'd0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end

        LOAD: begin
          if (handshake) begin
            // Shifting left puts the first byte of the word in bits 31:24.
            shift_reg <= {shift_reg[23:0], byte_in};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
            end
          end
        end

        WRITE: begin
          if (shift_reg == END_MARKER) begin
            // The terminator is consumed but never stored.
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            mem_write  <= 1'b1;
            mem_addy   <= word_addy;
            mem_data   <= shift_reg;
            word_addy  <= word_addy + 16'd1;
            word_count <= next_count;
            if (next_count == MAX_COUNT) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state      <= LOAD;
              byte_ready <= 1'b1;
              byte_cnt   <= 2'd0;
            end
          end
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b1;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Self-checking bench for instruction_loader. Three instances
//               cover the default build, a 3-word limit and a base address of
//               0xFFFF. Expected writes come from a word-level program model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  logic        start_s      [NI];
  logic [7:0]  byte_in_s    [NI];
  logic        byte_valid_s [NI];
  logic        byte_ready_s [NI];
  logic [15:0] mem_addy_s   [NI];
  logic [31:0] mem_data_s   [NI];
  logic        mem_write_s  [NI];
  logic        cpu_hold_s   [NI];
  logic        done_s       [NI];
  logic [16:0] word_count_s [NI];

  instruction_loader #(.BASE_ADDY(16'h0000), .MAX_WORDS(1024)) dut_a (
    .clock(clock), .reset(reset), .start(start_s[0]), .byte_in(byte_in_s[0]),
    .byte_valid(byte_valid_s[0]), .byte_ready(byte_ready_s[0]),
    .mem_addy(mem_addy_s[0]), .mem_data(mem_data_s[0]), .mem_write(mem_write_s[0]),
    .cpu_hold(cpu_hold_s[0]), .done(done_s[0]), .word_count(word_count_s[0]));

  instruction_loader #(.BASE_ADDY(16'h0000), .MAX_WORDS(3)) dut_m (
    .clock(clock), .reset(reset), .start(start_s[1]), .byte_in(byte_in_s[1]),
    .byte_valid(byte_valid_s[1]), .byte_ready(byte_ready_s[1]),
    .mem_addy(mem_addy_s[1]), .mem_data(mem_data_s[1]), .mem_write(mem_write_s[1]),
    .cpu_hold(cpu_hold_s[1]), .done(done_s[1]), .word_count(word_count_s[1]));

  instruction_loader #(.BASE_ADDY(16'hFFFF), .MAX_WORDS(1024)) dut_w (
    .clock(clock), .reset(reset), .start(start_s[2]), .byte_in(byte_in_s[2]),
    .byte_valid(byte_valid_s[2]), .byte_ready(byte_ready_s[2]),
    .mem_addy(mem_addy_s[2]), .mem_data(mem_data_s[2]), .mem_write(mem_write_s[2]),
    .cpu_hold(cpu_hold_s[2]), .done(done_s[2]), .word_count(word_count_s[2]));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- write monitor (samples mid low phase) ----------------
  logic [47:0] got    [NI][0:255];
  int          got_n  [NI] = '{0, 0, 0};
  int          hs_run [NI] = '{0, 0, 0};
  logic        prev_mw[NI] = '{1'b0, 1'b0, 1'b0};
  logic        after4 [NI] = '{1'b0, 1'b0, 1'b0};

  always begin
    @(negedge clock);
    #2;
    for (int k = 0; k < NI; k++) begin
      if (mem_write_s[k]) begin
        check("no back-to-back write", 48'(prev_mw[k]), 48'd0);
        if (got_n[k] < 256) got[k][got_n[k]] = {mem_addy_s[k], mem_data_s[k]};
        got_n[k]++;
      end
      prev_mw[k] = mem_write_s[k];
      if (after4[k]) check("ready low after 4th byte", 48'(byte_ready_s[k]), 48'd0);
      after4[k] = byte_ready_s[k] && byte_valid_s[k] && (hs_run[k] == 3);
      if (!byte_ready_s[k]) hs_run[k] = 0;
      else if (byte_valid_s[k]) hs_run[k]++;
    end
  end

  // ---------------- program buffer and reference model ----------------
  logic [7:0]  sbuf [0:63];
  int          sn;
  logic [47:0] exp_w [0:63];
  int          exp_n;
  bit          exp_done;

  // Splits the byte stream into big-endian words; stops at the marker or
  // once the instance's word limit is reached.
  function automatic void model(input int k);
    int base;
    int maxw;
    logic [31:0] w;
    base = (k == 2) ? 65535 : 0;
    maxw = (k == 1) ? 3 : 1024;
    exp_n = 0;
    exp_done = 1'b0;
    for (int i = 0; i + 3 < sn; i += 4) begin
      w = {sbuf[i], sbuf[i+1], sbuf[i+2], sbuf[i+3]};
      if (w == 32'hFFFFFFFF) begin
        exp_done = 1'b1;
        break;
      end
      exp_w[exp_n] = {16'((base + exp_n) % 65536), w};
      exp_n++;
      if (exp_n == maxw) begin
        exp_done = 1'b1;
        break;
      end
    end
  endfunction

  // Starts a load on instance k, streams sbuf, then checks against the model.
  task automatic load_and_check(input int k, input bit gaps, input string tag);
    int mark;
    int idx;
    int cyc;
    bit acc;
    @(negedge clock);
    start_s[k] = 1'b1;
    byte_valid_s[k] = 1'b0;
    mark = got_n[k];
    @(negedge clock);
    start_s[k] = 1'b0;
    #1;
    check({tag, " hold/done/ready after start"},
          48'({cpu_hold_s[k], done_s[k], byte_ready_s[k]}), 48'b101);
    check({tag, " word_count after start"}, 48'(word_count_s[k]), 48'd0);
    idx = 0;
    cyc = 0;
    while (idx < sn && !done_s[k] && cyc < 600) begin
      byte_in_s[k] = sbuf[idx];
      byte_valid_s[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = byte_valid_s[k] && byte_ready_s[k];
      @(negedge clock);
      if (acc) idx++;
      cyc++;
    end
    byte_valid_s[k] = 1'b0;
    cyc = 0;
    while (!done_s[k] && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    // One more cycle so the monitor has captured a write issued with done.
    @(negedge clock);
    #3;
    model(k);
    check({tag, " write count"}, 48'(got_n[k] - mark), 48'(exp_n));
    for (int i = 0; i < exp_n && i < got_n[k] - mark; i++)
      check({tag, " write addy/data"}, got[k][mark + i], exp_w[i]);
    check({tag, " done"}, 48'(done_s[k]), 48'(exp_done));
    check({tag, " cpu_hold"}, 48'(cpu_hold_s[k]), 48'(!exp_done));
    check({tag, " byte_ready"}, 48'(byte_ready_s[k]), 48'd0);
    check({tag, " word_count"}, 48'(word_count_s[k]), 48'(exp_n));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int           inst;
    int           nbytes;
    logic [127:0] stream;
    bit           gaps;
    int           exp_wc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int mark;
    int nw;
    logic [31:0] w;

    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0;
      byte_in_s[k] = 8'd0;
      byte_valid_s[k] = 1'b0;
    end

    vecs[0] = '{0, 12, {32'h00112233, 32'h44556677, 32'hFFFFFFFF, 32'h0}, 1'b0, 2};
    vecs[1] = '{0, 12, {32'h00112233, 32'h44556677, 32'hFFFFFFFF, 32'h0}, 1'b1, 2};
    vecs[2] = '{1, 16, {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10}, 1'b1, 3};
    vecs[3] = '{2, 12, {32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h0}, 1'b0, 2};
    vecs[4] = '{0, 8,  {32'hCAFEF00D, 32'hFFFFFFFF, 64'h0}, 1'b1, 1};

    // Reset state on every instance.
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("reset ready/write/hold/done",
            48'({byte_ready_s[k], mem_write_s[k], cpu_hold_s[k], done_s[k]}), 48'b0010);
      check("reset addy/data", {mem_addy_s[k], mem_data_s[k]}, 48'd0);
      check("reset word_count", 48'(word_count_s[k]), 48'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      sn = vecs[v].nbytes;
      for (int i = 0; i < sn; i++) sbuf[i] = vecs[v].stream[127 - 8*i -: 8];
      load_and_check(vecs[v].inst, vecs[v].gaps, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table word_count", v),
            48'(word_count_s[vecs[v].inst]), 48'(vecs[v].exp_wc));
    end

    // Word limit reached: offered bytes are never taken afterwards.
    mark = got_n[1];
    byte_in_s[1] = 8'h5A;
    byte_valid_s[1] = 1'b1;
    repeat (4) begin
      @(negedge clock);
      #1;
      check("limit: ready stays low", 48'(byte_ready_s[1]), 48'd0);
    end
    byte_valid_s[1] = 1'b0;
    check("limit: no extra writes", 48'(got_n[1] - mark), 48'd0);

    // Reset after two bytes of a word.
    mark = got_n[0];
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    byte_in_s[0] = 8'hAA;
    byte_valid_s[0] = 1'b1;
    @(negedge clock);
    byte_in_s[0] = 8'hBB;
    @(negedge clock);
    byte_valid_s[0] = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("midreset ready/write/hold/done",
          48'({byte_ready_s[0], mem_write_s[0], cpu_hold_s[0], done_s[0]}), 48'b0010);
    check("midreset addy/data", {mem_addy_s[0], mem_data_s[0]}, 48'd0);
    check("midreset word_count", 48'(word_count_s[0]), 48'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    check("midreset no write", 48'(got_n[0] - mark), 48'd0);
    sn = 12;
    for (int i = 0; i < 4; i++) begin
      sbuf[i]     = 8'(8'h11 * (i + 1));
      sbuf[i + 4] = 8'(8'h55 + 8'h11 * i);
      sbuf[i + 8] = 8'hFF;
    end
    load_and_check(0, 1'b1, "after midreset");

    // Randomised programs on all three instances.
    for (int r = 0; r < 12; r++) begin
      nw = $urandom_range(1, 5);
      sn = 0;
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        if (w == 32'hFFFFFFFF) w = 32'h0;
        for (int b = 0; b < 4; b++) sbuf[sn + b] = w[31 - 8*b -: 8];
        sn += 4;
      end
      for (int b = 0; b < 4; b++) sbuf[sn + b] = 8'hFF;
      sn += 4;
      load_and_check(r % NI, 1'b1, $sformatf("rand%0d", r));
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
